gtx_reset_sequencer: RTL and testbench



---
 rtl/nf10_gtx_pkg.sv | 19 +
 rtl/gtx_sig_sync.sv | 27 ++
 rtl/gtx_reset_sequencer.sv | 146 ++++++++++++++
 tb/tb_gtx_reset_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_gtx_pkg.sv
// Shared definitions for the GTX_DUAL tile reset sequencer: FSM encoding and
// the constants for the elastic-buffer recovery path.
package nf10_gtx_pkg;

  typedef enum logic [2:0] {
    PWRDN     = 3'd0,
    RST       = 3'd1,
    WAIT_LOCK = 3'd2,
    WAIT_DONE = 3'd3,
    LINK_UP   = 3'd4,
    RETRY     = 3'd5,
    FAILED    = 3'd6,
    BUFRST    = 3'd7
  } gtx_state_e;

  localparam int BUFRST_CYCLES = 4;
  localparam int RXBUF_ERR_BIT = 2;

endpackage

// File: rtl/gtx_sig_sync.sv
// Two-flop synchroniser bank for status bits arriving asynchronously from
// the GTX tile; every bit is synchronised independently.
module gtx_sig_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gtx_reset_sequencer.sv
// Power-up / reset sequencer for one GTX_DUAL tile with bounded retries.
// Define GTX_RSTSEQ_BUFRESET_EN to add lane-0 elastic buffer reset recovery.
module gtx_reset_sequencer
  import nf10_gtx_pkg::*;
#(
  parameter int PWRDN_CYCLES       = 256,
  parameter int RESET_PULSE_CYCLES = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int DONE_TIMEOUT       = 65536,
  parameter int MAX_RETRIES        = 3,
  parameter int TIMER_W            = 17
) (
  input  logic       CLK_IN,
  input  logic       RESET,
  input  logic       PLLLKDET,
  input  logic       RESETDONE0,
  input  logic       RESETDONE1,
  input  logic [2:0] RXBUFSTATUS0,
  output logic       PLLPOWERDOWN,
  output logic       GTXRESET,
  output logic       RXBUFRESET0,
  output logic       READY,
  output logic       FAIL,
  output logic [3:0] RETRY_COUNT
);

  localparam logic [3:0] MAX_RETRY_CNT = 4'(MAX_RETRIES);

  gtx_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         retryCnt_q, retryCnt_d;
  logic               pllPd_q, gtxRst_q, ready_q, fail_q;
  logic               expired;
  logic [3:0]         syncOut;
  logic               lock_s, done0_s, done1_s, bufErr_s;
  logic               unused_ok;

  gtx_sig_sync #(.WIDTH(4)) u_sync (
    .clk_i (CLK_IN),
    .rst_i (RESET),
    .d_i   ({RXBUFSTATUS0[RXBUF_ERR_BIT], RESETDONE1, RESETDONE0, PLLLKDET}),
    .q_o   (syncOut)
  );

  assign {bufErr_s, done1_s, done0_s, lock_s} = syncOut;

  // Each timed state loads (duration - 1) on entry, so it lasts exactly its duration.
  function automatic logic [TIMER_W-1:0] reloadFor(input gtx_state_e s);
    case (s)
      PWRDN:     reloadFor = TIMER_W'(PWRDN_CYCLES - 1);
      RST:       reloadFor = TIMER_W'(RESET_PULSE_CYCLES - 1);
      WAIT_LOCK: reloadFor = TIMER_W'(LOCK_TIMEOUT - 1);
      WAIT_DONE: reloadFor = TIMER_W'(DONE_TIMEOUT - 1);
      BUFRST:    reloadFor = TIMER_W'(BUFRST_CYCLES - 1);
      default:   reloadFor = '0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    retryCnt_d = retryCnt_q;
    expired    = (timer_q == '0);
    case (state_q)
      PWRDN:     if (expired) state_d = RST;
      RST:       if (expired) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s)       state_d = WAIT_DONE;
        else if (expired) state_d = RETRY;
      end
      WAIT_DONE: begin
        if (!lock_s)                    state_d = RETRY;
        else if (done0_s && done1_s)    state_d = LINK_UP;
        else if (expired)               state_d = RETRY;
      end
      LINK_UP: begin
        if (!lock_s || !done0_s || !done1_s) state_d = RETRY;
`ifdef GTX_RSTSEQ_BUFRESET_EN
        else if (bufErr_s)                   state_d = BUFRST;
`endif
      end
`ifdef GTX_RSTSEQ_BUFRESET_EN
      BUFRST: begin
        if (!lock_s)      state_d = RETRY;
        else if (expired) state_d = LINK_UP;
      end
`endif
      RETRY: begin
        if (retryCnt_q == MAX_RETRY_CNT) begin
          state_d = FAILED;
        end else begin
          retryCnt_d = retryCnt_q + 4'd1;
          state_d    = RST;
        end
      end
      FAILED:  state_d = FAILED;
      default: state_d = PWRDN;
    endcase

    if (state_d != state_q) timer_d = reloadFor(state_d);
    else if (!expired)      timer_d = timer_q - TIMER_W'(1);
    else                    timer_d = timer_q;
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      state_q    <= PWRDN;
      timer_q    <= TIMER_W'(PWRDN_CYCLES - 1);
      retryCnt_q <= '0;
      pllPd_q    <= 1'b1;
      gtxRst_q   <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retryCnt_q <= retryCnt_d;
      pllPd_q    <= (state_d == PWRDN);
      gtxRst_q   <= (state_d == PWRDN) || (state_d == RST) || (state_d == FAILED);
      ready_q    <= (state_d == LINK_UP);
      fail_q     <= (state_d == FAILED);
    end
  end

`ifdef GTX_RSTSEQ_BUFRESET_EN
  logic rxBufRst_q;

  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) rxBufRst_q <= 1'b0;
    else       rxBufRst_q <= (state_d == BUFRST);
  end

  assign RXBUFRESET0 = rxBufRst_q;
  assign unused_ok   = &{1'b0, RXBUFSTATUS0[1:0]};
`else
  assign RXBUFRESET0 = 1'b0;
  assign unused_ok   = &{1'b0, RXBUFSTATUS0[1:0], bufErr_s};
`endif

  assign PLLPOWERDOWN = pllPd_q;
  assign GTXRESET     = gtxRst_q;
  assign READY        = ready_q;
  assign FAIL         = fail_q;
  assign RETRY_COUNT  = retryCnt_q;

endmodule

// File: tb/tb_gtx_reset_sequencer.sv
// Directed bench for gtx_reset_sequencer with small timing parameters;
// expected cycle counts are written out per step from the sequencing rules.
module tb_gtx_reset_sequencer;

`ifdef GTX_RSTSEQ_BUFRESET_EN
  localparam logic BUF_EN = 1'b1;
`else
  localparam logic BUF_EN = 1'b0;
`endif

  logic       CLK_IN = 1'b0;
  logic       RESET;
  logic       PLLLKDET, RESETDONE0, RESETDONE1;
  logic [2:0] RXBUFSTATUS0;
  logic       PLLPOWERDOWN, GTXRESET, RXBUFRESET0, READY, FAIL;
  logic [3:0] RETRY_COUNT;

  int total = 0;
  int bad   = 0;

  gtx_reset_sequencer #(
    .PWRDN_CYCLES       (8),
    .RESET_PULSE_CYCLES (4),
    .LOCK_TIMEOUT       (32),
    .DONE_TIMEOUT       (32),
    .MAX_RETRIES        (2),
    .TIMER_W            (17)
  ) dut (
    .CLK_IN       (CLK_IN),
    .RESET        (RESET),
    .PLLLKDET     (PLLLKDET),
    .RESETDONE0   (RESETDONE0),
    .RESETDONE1   (RESETDONE1),
    .RXBUFSTATUS0 (RXBUFSTATUS0),
    .PLLPOWERDOWN (PLLPOWERDOWN),
    .GTXRESET     (GTXRESET),
    .RXBUFRESET0  (RXBUFRESET0),
    .READY        (READY),
    .FAIL         (FAIL),
    .RETRY_COUNT  (RETRY_COUNT)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK_IN);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic lock, input logic d0, input logic d1,
                               input logic [2:0] bufStatus);
    PLLLKDET     = lock;
    RESETDONE0   = d0;
    RESETDONE1   = d1;
    RXBUFSTATUS0 = bufStatus;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reset is released 1 unit after an edge, so the next edge is cycle 1.
  task automatic applyReset();
    RESET = 1'b1;
    tick(3);
    RESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
    RESET = 1'b1;
    tick(2);
    checkOutput("rst_pllpd",  4'(PLLPOWERDOWN), 4'd1);
    checkOutput("rst_gtxrst", 4'(GTXRESET),     4'd1);
    checkOutput("rst_rxbuf",  4'(RXBUFRESET0),  4'd0);
    checkOutput("rst_ready",  4'(READY),        4'd0);
    checkOutput("rst_fail",   4'(FAIL),         4'd0);
    checkOutput("rst_count",  RETRY_COUNT,      4'd0);
    RESET = 1'b0;

    // Clean bring-up
    tick(7);
    checkOutput("s1_pllpd_c7",  4'(PLLPOWERDOWN), 4'd1);
    tick(1);
    checkOutput("s1_pllpd_c8",  4'(PLLPOWERDOWN), 4'd0);
    checkOutput("s1_gtx_c8",    4'(GTXRESET),     4'd1);
    tick(3);
    checkOutput("s1_gtx_c11",   4'(GTXRESET),     4'd1);
    tick(1);
    checkOutput("s1_gtx_c12",   4'(GTXRESET),     4'd0);
    tick(10);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    tick(5);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b000);
    tick(2);
    checkOutput("s1_ready_d2",  4'(READY),        4'd0);
    tick(1);
    checkOutput("s1_ready_d3",  4'(READY),        4'd1);
    checkOutput("s1_count",     RETRY_COUNT,      4'd0);
    checkOutput("s1_fail",      4'(FAIL),         4'd0);

    // Elastic buffer error pulse while linked
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b100);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b000);
    tick(1);
    checkOutput("s5_rxbuf_c2",  4'(RXBUFRESET0),  4'd0);
    checkOutput("s5_ready_c2",  4'(READY),        4'd1);
    tick(1);
    checkOutput("s5_rxbuf_c3",  4'(RXBUFRESET0),  4'(BUF_EN));
    checkOutput("s5_ready_c3",  4'(READY),        4'(!BUF_EN));
    tick(3);
    checkOutput("s5_rxbuf_c6",  4'(RXBUFRESET0),  4'(BUF_EN));
    checkOutput("s5_ready_c6",  4'(READY),        4'(!BUF_EN));
    tick(1);
    checkOutput("s5_rxbuf_c7",  4'(RXBUFRESET0),  4'd0);
    checkOutput("s5_ready_c7",  4'(READY),        4'd1);
    checkOutput("s5_count",     RETRY_COUNT,      4'd0);

    // One-cycle lock loss while linked
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b000);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b000);
    tick(1);
    checkOutput("s3_ready_c2",  4'(READY),        4'd1);
    tick(1);
    checkOutput("s3_ready_c3",  4'(READY),        4'd0);
    checkOutput("s3_gtx_c3",    4'(GTXRESET),     4'd0);
    tick(1);
    checkOutput("s3_gtx_c4",    4'(GTXRESET),     4'd1);
    checkOutput("s3_count_c4",  RETRY_COUNT,      4'd1);
    tick(3);
    checkOutput("s3_gtx_c7",    4'(GTXRESET),     4'd1);
    tick(1);
    checkOutput("s3_gtx_c8",    4'(GTXRESET),     4'd0);
    tick(1);
    checkOutput("s3_ready_c9",  4'(READY),        4'd0);
    tick(1);
    checkOutput("s3_ready_c10", 4'(READY),        4'd1);
    checkOutput("s3_pllpd",     4'(PLLPOWERDOWN), 4'd0);
    checkOutput("s3_count_c10", RETRY_COUNT,      4'd1);

    // Lane 1 never finishes while lock holds
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b000);
    applyReset();
    checkOutput("s4_count_rst", RETRY_COUNT,      4'd0);
    tick(12);
    checkOutput("s4_gtx_c12",   4'(GTXRESET),     4'd0);
    tick(32);
    checkOutput("s4_gtx_c44",   4'(GTXRESET),     4'd0);
    checkOutput("s4_count_c44", RETRY_COUNT,      4'd0);
    checkOutput("s4_ready_c44", 4'(READY),        4'd0);
    tick(1);
    checkOutput("s4_gtx_c45",   4'(GTXRESET),     4'd0);
    tick(1);
    checkOutput("s4_gtx_c46",   4'(GTXRESET),     4'd1);
    checkOutput("s4_count_c46", RETRY_COUNT,      4'd1);
    checkOutput("s4_pllpd_c46", 4'(PLLPOWERDOWN), 4'd0);

    // Lock never asserts: retries run out
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
    applyReset();
    tick(44);
    checkOutput("s2_gtx_c44",   4'(GTXRESET),     4'd0);
    checkOutput("s2_count_c44", RETRY_COUNT,      4'd0);
    tick(1);
    checkOutput("s2_gtx_c45",   4'(GTXRESET),     4'd1);
    checkOutput("s2_count_c45", RETRY_COUNT,      4'd1);
    tick(3);
    checkOutput("s2_gtx_c48",   4'(GTXRESET),     4'd1);
    tick(1);
    checkOutput("s2_gtx_c49",   4'(GTXRESET),     4'd0);
    tick(32);
    checkOutput("s2_gtx_c81",   4'(GTXRESET),     4'd0);
    checkOutput("s2_count_c81", RETRY_COUNT,      4'd1);
    tick(1);
    checkOutput("s2_gtx_c82",   4'(GTXRESET),     4'd1);
    checkOutput("s2_count_c82", RETRY_COUNT,      4'd2);
    tick(36);
    checkOutput("s2_gtx_c118",  4'(GTXRESET),     4'd0);
    checkOutput("s2_fail_c118", 4'(FAIL),         4'd0);
    tick(1);
    checkOutput("s2_fail_c119", 4'(FAIL),         4'd1);
    checkOutput("s2_gtx_c119",  4'(GTXRESET),     4'd1);
    checkOutput("s2_ready_119", 4'(READY),        4'd0);
    checkOutput("s2_count_119", RETRY_COUNT,      4'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b000);
    tick(20);
    checkOutput("s2_fail_stky", 4'(FAIL),         4'd1);
    checkOutput("s2_gtx_stky",  4'(GTXRESET),     4'd1);
    checkOutput("s2_rdy_stky",  4'(READY),        4'd0);
    RESET = 1'b1;
    #1;
    checkOutput("s2_fail_clr",  4'(FAIL),         4'd0);
    checkOutput("s2_count_clr", RETRY_COUNT,      4'd0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
    tick(1);
    RESET = 1'b0;

    // Reset asserted in the middle of WAIT_LOCK after one retry
    tick(50);
    checkOutput("s6_count_pre", RETRY_COUNT,      4'd1);
    checkOutput("s6_gtx_pre",   4'(GTXRESET),     4'd0);
    RESET = 1'b1;
    #1;
    checkOutput("s6_pllpd",     4'(PLLPOWERDOWN), 4'd1);
    checkOutput("s6_gtx",       4'(GTXRESET),     4'd1);
    checkOutput("s6_count",     RETRY_COUNT,      4'd0);
    checkOutput("s6_fail",      4'(FAIL),         4'd0);
    tick(2);
    RESET = 1'b0;
    tick(7);
    checkOutput("s6_pllpd_c7",  4'(PLLPOWERDOWN), 4'd1);
    tick(1);
    checkOutput("s6_pllpd_c8",  4'(PLLPOWERDOWN), 4'd0);
    tick(4);
    checkOutput("s6_gtx_c12",   4'(GTXRESET),     4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
